// File: rtl/vending_change_dispenser.sv
// Change dispenser: pays out a whole-dollar change amount one $1 pulse at a time,
// using a pulse/ack handshake with the hopper and reporting done or fault.
module vending_change_dispenser #(
  parameter int unsigned AMT_W       = 4,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic             disp_pulse,
  input  logic             hopper_ack,
  input  logic             hopper_empty,
  input  logic             clear_fault,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] dispensed,
  output logic [AMT_W-1:0] remaining
);

  // One timer serves both the ack window and the inter-pulse gap.
  localparam int unsigned TMR_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_FAULT    = 3'd5;

  logic [2:0]       r_state;
  logic [TMR_W-1:0] r_timer;
  logic [AMT_W-1:0] r_dispensed;
  logic [AMT_W-1:0] r_remaining;
  logic             r_req_ready;
  logic             r_disp_pulse;
  logic             r_busy;
  logic             r_done;
  logic             r_fault;

  logic [2:0]       w_state_nxt;
  logic [TMR_W-1:0] w_timer_nxt;
  logic [AMT_W-1:0] w_dispensed_nxt;
  logic [AMT_W-1:0] w_remaining_nxt;

  // State, counters and Moore outputs; outputs are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_dispensed  <= '0;
      r_remaining  <= '0;
      r_req_ready  <= 1'b1;
      r_disp_pulse <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_dispensed  <= w_dispensed_nxt;
      r_remaining  <= w_remaining_nxt;
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_disp_pulse <= (w_state_nxt == S_ISSUE);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_DONE);
      r_fault      <= (w_state_nxt == S_FAULT);
    end
  end

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_dispensed_nxt = r_dispensed;
    w_remaining_nxt = r_remaining;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_remaining_nxt = req_amount;
          w_dispensed_nxt = '0;
          if (req_amount == '0) begin
            w_state_nxt = S_DONE;
          end else if (hopper_empty) begin
            w_state_nxt = S_FAULT;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT_ACK;
        w_timer_nxt = '0;
      end
      S_WAIT_ACK: begin
        // An ack in the final window cycle still counts.
        if (hopper_ack) begin
          w_remaining_nxt = r_remaining - AMT_W'(1);
          w_dispensed_nxt = r_dispensed + AMT_W'(1);
          w_timer_nxt     = '0;
          w_state_nxt     = (r_remaining == AMT_W'(1)) ? S_DONE : S_GAP;
        end else if (r_timer == TMR_W'(ACK_TIMEOUT - 1)) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      S_GAP: begin
        if (r_timer == TMR_W'(GAP_CYCLES - 1)) begin
          w_timer_nxt = '0;
          w_state_nxt = hopper_empty ? S_FAULT : S_ISSUE;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      S_FAULT: begin
        if (clear_fault) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign req_ready  = r_req_ready;
  assign disp_pulse = r_disp_pulse;
  assign busy       = r_busy;
  assign done       = r_done;
  assign fault      = r_fault;
  assign dispensed  = r_dispensed;
  assign remaining  = r_remaining;

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Bench for vending_change_dispenser: directed scenarios plus random traffic,
// checked every cycle against a payout-schedule model.
module tb_vending_change_dispenser;

  localparam int unsigned AMT_W  = 4;
  localparam int unsigned ACK_TO = 15;
  localparam int unsigned GAP    = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             req_ready;
  logic             disp_pulse;
  logic             hopper_ack = 1'b0;
  logic             hopper_empty = 1'b0;
  logic             clear_fault = 1'b0;
  logic             busy;
  logic             done;
  logic             fault;
  logic [AMT_W-1:0] dispensed;
  logic [AMT_W-1:0] remaining;

  vending_change_dispenser #(
    .AMT_W      (AMT_W),
    .ACK_TIMEOUT(ACK_TO),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_amount  (req_amount),
    .req_ready   (req_ready),
    .disp_pulse  (disp_pulse),
    .hopper_ack  (hopper_ack),
    .hopper_empty(hopper_empty),
    .clear_fault (clear_fault),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .dispensed   (dispensed),
    .remaining   (remaining)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model of the payout: what is owed/paid and where we are in the pulse schedule.
  bit m_pulse;   // a $1 command goes out this cycle
  int m_wait;    // >0: this is the m_wait-th cycle waiting for the hopper
  int m_gap;     // >0: gap cycles still to sit out before the next pulse
  bit m_done;
  bit m_fault;
  int m_owed;
  int m_paid;

  // Stimulus settings consumed by tick(); ack mode 0 none, 1 prompt, 2 random, 3 forced.
  bit             t_valid = 0;
  logic [AMT_W-1:0] t_amt = '0;
  int             t_ack_mode = 0;
  bit             t_empty = 0;
  bit             t_clr = 0;
  bit             t_rst = 1;

  bit s_pulse, s_done, s_ready;
  int n_pulse = 0;
  int n_done_seen = 0;

  function automatic bit m_busy();
    return m_pulse || (m_wait > 0) || (m_gap > 0) || m_done || m_fault;
  endfunction

  task automatic model_reset();
    m_pulse = 0; m_wait = 0; m_gap = 0; m_done = 0; m_fault = 0;
    m_owed = 0; m_paid = 0;
  endtask

  // Advance the model across one rising edge using the inputs now on the pins.
  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (!m_busy()) begin
      if (req_valid) begin
        m_owed = int'(req_amount);
        m_paid = 0;
        if (m_owed == 0) m_done = 1;
        else if (hopper_empty) m_fault = 1;
        else m_pulse = 1;
      end
    end else if (m_pulse) begin
      m_pulse = 0;
      m_wait  = 1;
    end else if (m_wait > 0) begin
      if (hopper_ack) begin
        m_owed = m_owed - 1;
        m_paid = m_paid + 1;
        m_wait = 0;
        if (m_owed == 0) m_done = 1;
        else m_gap = int'(GAP);
      end else if (m_wait == int'(ACK_TO)) begin
        m_wait  = 0;
        m_fault = 1;
      end else begin
        m_wait = m_wait + 1;
      end
    end else if (m_gap > 0) begin
      if (m_gap == 1) begin
        m_gap = 0;
        if (hopper_empty) m_fault = 1;
        else m_pulse = 1;
      end else begin
        m_gap = m_gap - 1;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (m_fault) begin
      if (clear_fault) m_fault = 0;
    end
  endtask

  task automatic check_outputs();
    logic [12:0] act, exp;
    act = {req_ready, disp_pulse, busy, done, fault, dispensed, remaining};
    exp = {!m_busy(), m_pulse, m_busy(), m_done, m_fault, AMT_W'(m_paid), AMT_W'(m_owed)};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cycle_outputs t=%0t got=%h want=%h (ready,pulse,busy,done,fault,disp,rem)",
               $time, act, exp);
    end
  endtask

  task automatic lit(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // One cycle: check this cycle's outputs, drive the next inputs, step the model.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    s_pulse = disp_pulse; s_done = done; s_ready = req_ready;
    n_pulse += int'(disp_pulse);
    n_done_seen += int'(done);
    req_valid  = t_valid;
    req_amount = t_amt;
    case (t_ack_mode)
      0: hopper_ack = 1'b0;
      1: hopper_ack = (m_wait == 1);
      2: hopper_ack = ($urandom_range(0, 2) == 0);
      default: hopper_ack = 1'b1;
    endcase
    hopper_empty = t_empty;
    clear_fault  = t_clr;
    reset        = t_rst;
    model_step();
  endtask

  task automatic idle_inputs();
    t_valid = 0; t_amt = '0; t_ack_mode = 1; t_empty = 0; t_clr = 0; t_rst = 0;
  endtask

  logic [7:0] pm, dm, rm;

  initial begin
    model_reset();
    t_rst = 1;
    repeat (3) tick();
    lit("reset_req_ready", int'(req_ready), 1);
    lit("reset_busy", int'(busy), 0);
    lit("reset_dispensed", int'(dispensed), 0);
    idle_inputs();
    tick();
    tick();

    // Two dollars with prompt acks: pulses at 1 and 5, done at 7, ready at 8.
    t_valid = 1; t_amt = 4'd2; tick();
    t_valid = 0;
    pm = '0; dm = '0; rm = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      pm[k-1] = s_pulse; dm[k-1] = s_done; rm[k-1] = s_ready;
    end
    lit("t1_pulse_cycles", int'(pm), int'(8'b0001_0001));
    lit("t1_done_cycle", int'(dm), int'(8'b0100_0000));
    lit("t1_ready_cycle", int'(rm), int'(8'b1000_0000));
    lit("t1_dispensed", int'(dispensed), 2);
    lit("t1_remaining", int'(remaining), 0);

    // Zero-dollar request, then a stray ack while idle.
    t_valid = 1; t_amt = 4'd0; tick();
    t_valid = 0; n_pulse = 0; tick();
    lit("t2_done", int'(s_done), 1);
    t_ack_mode = 3; tick(); tick();
    t_ack_mode = 1; tick();
    lit("t2_no_pulse", n_pulse, 0);
    lit("t2_dispensed", int'(dispensed), 0);

    // Hopper never acks: one pulse, fault after the ack window, valid ignored.
    t_valid = 1; t_amt = 4'd3; t_ack_mode = 0; tick();
    n_pulse = 0;
    for (int k = 1; k <= 20; k++) tick();
    lit("t3_one_pulse", n_pulse, 1);
    lit("t3_fault", int'(fault), 1);
    lit("t3_remaining", int'(remaining), 3);
    lit("t3_dispensed", int'(dispensed), 0);
    t_valid = 0; t_clr = 1; tick();
    t_clr = 0; t_ack_mode = 1; tick();
    lit("t3_ready_after_clear", int'(s_ready), 1);

    // Hopper runs dry during the first gap.
    t_valid = 1; t_amt = 4'd2; tick();
    t_valid = 0; n_pulse = 0;
    tick(); tick();
    t_empty = 1;
    for (int k = 3; k <= 10; k++) tick();
    lit("t4_one_pulse", n_pulse, 1);
    lit("t4_fault", int'(fault), 1);
    lit("t4_dispensed", int'(dispensed), 1);
    lit("t4_remaining", int'(remaining), 1);
    t_empty = 0; t_clr = 1; tick();
    t_clr = 0; tick();

    // Reset in the middle of a gap after two acks.
    t_valid = 1; t_amt = 4'd5; tick();
    t_valid = 0;
    for (int k = 1; k <= 7; k++) tick();
    lit("t5_dispensed_pre", int'(dispensed), 2);
    #2 reset = 1'b1; t_rst = 1;
    #1;
    lit("t5_async_busy", int'(busy), 0);
    lit("t5_async_dispensed", int'(dispensed), 0);
    lit("t5_async_ready", int'(req_ready), 1);
    model_reset();
    repeat (3) tick();
    t_rst = 0; tick();
    n_pulse = 0;
    repeat (10) tick();
    lit("t5_no_pulse_after_reset", n_pulse, 0);
    t_valid = 1; t_amt = 4'd1; tick();
    t_valid = 0;
    repeat (6) tick();
    lit("t5_new_dispensed", int'(dispensed), 1);

    // Full-scale request with valid held high throughout.
    t_valid = 1; t_amt = 4'd15; tick();
    n_pulse = 0; n_done_seen = 0;
    for (int k = 1; k <= 59; k++) tick();
    lit("t6_pulses", n_pulse, 15);
    lit("t6_done_count", n_done_seen, 1);
    lit("t6_dispensed", int'(dispensed), 15);
    lit("t6_remaining", int'(remaining), 0);
    tick();
    lit("t6_ready_at_idle", int'(s_ready), 1);
    t_valid = 0;
    repeat (70) tick();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      t_valid    = ($urandom_range(0, 3) == 0);
      t_amt      = AMT_W'($urandom_range(0, 15));
      t_ack_mode = ($urandom_range(0, 3) == 0) ? 1 : 2;
      t_empty    = ($urandom_range(0, 15) == 0);
      t_clr      = ($urandom_range(0, 7) == 0);
      t_rst      = ($urandom_range(0, 499) == 0);
      tick();
    end
    idle_inputs();
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vending_change_dispenser.md
Name: vending_change_dispenser

Overview:
- Return-direction counterpart to the vending FSM: takes a change amount in whole dollars and pays it out one dollar at a time to a coin/bill hopper.
- Uses a per-dollar pulse/ack handshake with the hopper and reports completion or a fault.
- Sits between the vending controller (request side) and the hopper driver (dispense side).

Parameters:
- AMT_W, 4, width of the change amount and the counters (max request 2^AMT_W-1).
- ACK_TIMEOUT, 15, number of WAIT_ACK cycles allowed without a hopper ack before the block faults.
- GAP_CYCLES, 2, idle cycles between an ack and the next dispense pulse (minimum 1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  change request present.
- req_amount  in  AMT_W  dollars to return; sampled on accept.
- req_ready  out  1  high only in IDLE.
- disp_pulse  out  1  one-cycle command to the hopper to drop $1.
- hopper_ack  in  1  hopper confirms one $1 dropped.
- hopper_empty  in  1  hopper has no stock.
- clear_fault  in  1  leaves FAULT.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion strobe.
- fault  out  1  high while in FAULT.
- dispensed  out  AMT_W  dollars confirmed in the current or last request.
- remaining  out  AMT_W  dollars still owed.

Behaviour:
- Reset (async, immediate): state=IDLE; outputs as follows.
  - 0: disp_pulse, done, fault, busy, dispensed, remaining, timer.
  - 1: req_ready.
- Reset mid-operation abandons the request; no pulse is emitted after reset is released unless a new request arrives.
- States: IDLE, ISSUE, WAIT_ACK, GAP, DONE, FAULT. All outputs are Moore, decoded from registered state and counters.
- IDLE:
  - Accept on the edge where req_valid=1 and state is IDLE.
  - On accept: remaining<=req_amount, dispensed<=0.
  - If req_amount==0, next state is DONE.
  - Else if hopper_empty=1, next state is FAULT.
  - Otherwise next state is ISSUE.
- ISSUE:
  - disp_pulse=1 for this single cycle.
  - Next state is WAIT_ACK, with timer cleared.
  - hopper_ack is ignored in ISSUE.
- WAIT_ACK:
  - On hopper_ack=1: remaining-=1, dispensed+=1. If the old remaining==1, go to DONE; otherwise go to GAP.
  - If no ack by the ACK_TIMEOUT-th WAIT_ACK cycle, go to FAULT with counters unchanged.
  - If the ack arrives in that same last cycle, the ack wins.
- GAP:
  - Stays for exactly GAP_CYCLES cycles.
  - Then re-checks hopper_empty: go to FAULT if it is 1, otherwise go to ISSUE.
- DONE: done=1 for one cycle, then IDLE. dispensed and remaining hold until the next accept.
- FAULT:
  - fault=1; req_ready=0; remaining shows the undelivered amount.
  - Holds until clear_fault=1, then IDLE.
  - clear_fault is ignored in other states.
- hopper_ack outside WAIT_ACK is ignored (no counter change).
- req_valid while busy is ignored; the request is not queued.
- Arithmetic:
  - Counters are AMT_W bits and never wrap: dispensed <= req_amount and remaining >= 0 by construction.
  - timer is wide enough for ACK_TIMEOUT.
- Latency with ack one cycle after each pulse:
  - First pulse in the cycle after accept.
  - Successive pulses every GAP_CYCLES+2 cycles.
  - done one cycle after the final ack.

Test Plan:
1. Reset, then req_amount=2 accepted at edge 0, ack in each cycle following a pulse -> disp_pulse in cycles 1 and 5, done in cycle 7, dispensed=2, remaining=0, req_ready back at cycle 8.
2. req_amount=0 -> no disp_pulse, done in cycle 1, dispensed=0; stray hopper_ack in IDLE leaves dispensed=0.
3. req_amount=3, hopper_ack never asserted -> exactly one pulse, FAULT after 15 WAIT_ACK cycles, remaining=3, dispensed=0; req_valid ignored; clear_fault -> IDLE, req_ready=1.
4. req_amount=2, hopper_empty raised during the first GAP -> one pulse only, fault=1, dispensed=1, remaining=1.
5. req_amount=5, reset asserted mid-GAP after 2 acks -> outputs zero asynchronously, no further pulses after release; new req_amount=1 completes with dispensed=1.
6. req_amount=15 with prompt acks, req_valid held high throughout -> exactly 15 pulses, dispensed=15, no counter wrap, single done, request re-accepted only after return to IDLE.
